// File: rtl/mem_line_pkg.sv
// Shared types and widths for the cache line memory master.
package mem_line_pkg;

    localparam int unsigned ADDR_W = 22;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_line_master_if.sv
// Request (cache side) and memory bus signals of the line master.
// master: the engine; slave: the cache requester and main memory together.
interface mem_line_master_if #(
    parameter int unsigned WORDS = 4
);
    import mem_line_pkg::*;

    logic                      req_valid;
    logic                      req_ready;
    logic                      req_wr;
    logic [ADDR_W-1:0]         req_addr;
    logic [WORD_W*WORDS-1:0]   req_wdata;
    logic [WORD_W*WORDS-1:0]   rd_line;
    logic                      done;
    logic [ADDR_W-1:0]         mem_addr;
    logic                      mem_re;
    logic                      mem_we;
    logic [WORD_W-1:0]         mem_wrt_data;
    logic [WORD_W-1:0]         mem_rd_data;

    modport master (
        input  req_valid, req_wr, req_addr, req_wdata, mem_rd_data,
        output req_ready, rd_line, done, mem_addr, mem_re, mem_we, mem_wrt_data
    );

    modport slave (
        output req_valid, req_wr, req_addr, req_wdata, mem_rd_data,
        input  req_ready, rd_line, done, mem_addr, mem_re, mem_we, mem_wrt_data
    );

endinterface

// File: rtl/mem_line_ctr.sv
// Word offset counter for one line transfer: loads a start offset, increments
// modulo WORDS, and flags the cycle whose increment completes the line.
module mem_line_ctr #(
    parameter int unsigned WORDS = 4,
    parameter int unsigned OFS_W = $clog2(WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [OFS_W-1:0] start,
    input  logic             inc,
    output logic [OFS_W-1:0] ofs,
    output logic [OFS_W-1:0] ofs_inc,
    output logic             last
);

    logic [OFS_W-1:0] cnt;

    // WORDS is a power of two, so natural overflow gives the in-line wrap.
    assign ofs_inc = ofs + 1'b1;
    // High while the increment in progress is the WORDS-th since load.
    assign last    = (cnt == OFS_W'(WORDS - 1));

    // Offset and increment-count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ofs <= '0;
            cnt <= '0;
        end else if (load) begin
            ofs <= start;
            cnt <= '0;
        end else if (inc) begin
            ofs <= ofs_inc;
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_line_master.sv
// Line fill / writeback engine for the main data memory.
// Optional feature: define WRAP_FILL_EN for critical-word-first ordering.
module mem_line_master
    import mem_line_pkg::*;
#(
    parameter int unsigned WORDS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_line_master_if.master   bus
);

    localparam int unsigned OFS_W  = $clog2(WORDS);
    localparam int unsigned LINE_W = WORD_W * WORDS;

    state_t                    state, state_nxt;
    logic                      accept;
    logic                      wr_q;
    logic [ADDR_W-OFS_W-1:0]   base_q;
    logic [LINE_W-1:0]         line_q;
    logic [LINE_W-1:0]         rd_line_q;
    logic [OFS_W-1:0]          start_ofs, ofs, ofs_inc;
    logic                      last;
    logic                      ready_q, done_q, re_q, we_q;
    logic [ADDR_W-1:0]         addr_q;
    logic [WORD_W-1:0]         wdata_q;

`ifdef WRAP_FILL_EN
    assign start_ofs = bus.req_addr[OFS_W-1:0];
`else
    assign start_ofs = '0;
`endif

    assign accept = (state == IDLE) && bus.req_valid;

    mem_line_ctr #(
        .WORDS (WORDS),
        .OFS_W (OFS_W)
    ) u_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept),
        .start   (start_ofs),
        .inc     (state == XFER),
        .ofs     (ofs),
        .ofs_inc (ofs_inc),
        .last    (last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = XFER;
            XFER:    if (last)   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the request on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q   <= 1'b0;
            base_q <= '0;
            line_q <= '0;
        end else if (accept) begin
            wr_q   <= bus.req_wr;
            base_q <= bus.req_addr[ADDR_W-1:OFS_W];
            line_q <= bus.req_wdata;
        end
    end

    // Registered outputs. Address and write data are loaded one edge ahead
    // (from the request on accept, from ofs_inc during XFER) so every memory
    // signal leaves a flop; they hold after the last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            ready_q <= (state_nxt == IDLE);
            done_q  <= (state_nxt == DONE);
            if (accept) begin
                re_q    <= !bus.req_wr;
                we_q    <= bus.req_wr;
                addr_q  <= {bus.req_addr[ADDR_W-1:OFS_W], start_ofs};
                wdata_q <= bus.req_wdata[WORD_W*start_ofs +: WORD_W];
            end else if (state == XFER) begin
                if (last) begin
                    re_q <= 1'b0;
                    we_q <= 1'b0;
                end else begin
                    addr_q  <= {base_q, ofs_inc};
                    wdata_q <= line_q[WORD_W*ofs_inc +: WORD_W];
                end
            end
        end
    end

    // Fill capture: each read word lands in the slot of its own offset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   rd_line_q <= '0;
        else if (state == XFER && !wr_q) rd_line_q[WORD_W*ofs +: WORD_W] <= bus.mem_rd_data;
    end

    assign bus.req_ready    = ready_q;
    assign bus.done         = done_q;
    assign bus.mem_re       = re_q;
    assign bus.mem_we       = we_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_wrt_data = wdata_q;
    assign bus.rd_line      = rd_line_q;

endmodule

// File: tb/tb_mem_line_master.sv
// Scoreboard bench for mem_line_master (WORDS=4); honours WRAP_FILL_EN.
module tb_mem_line_master;

    localparam int unsigned WORDS = 4;
    localparam int unsigned OFS_W = 2;

    typedef struct {
        logic        we;
        logic [21:0] addr;
        logic [31:0] data;
    } acc_t;

    typedef struct {
        logic         wr;
        logic [21:0]  base;
        logic [127:0] line;
    } line_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_line_master_if #(.WORDS(WORDS)) bus ();

    mem_line_master #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    logic [31:0] mem [0:1023];
    acc_t        acc_q[$];
    line_t       line_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          last_acc = 0;
    logic        prev_done = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Memory model: accesses happen while clk is low.
    always @(negedge clk) begin
        if (bus.mem_re) bus.mem_rd_data = mem[bus.mem_addr[9:0]];
        if (bus.mem_we) mem[bus.mem_addr[9:0]] = bus.mem_wrt_data;
    end

    // Monitor: per-cycle invariants plus scoreboard pops.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_done = 1'b0;
        end else begin
            acc_t  e;
            line_t l;
            logic [127:0] obs;
            check("re_we_excl", 128'(bus.mem_re && bus.mem_we), 128'(0));
            check("done_twice", 128'(prev_done && bus.done), 128'(0));
            prev_done = bus.done;
            if (bus.mem_re || bus.mem_we) begin
                check("ready_busy", 128'(bus.req_ready), 128'(0));
                if (acc_q.size() == 0) begin
                    check("acc_underflow", 128'(1), 128'(0));
                end else begin
                    e = acc_q.pop_front();
                    check("acc_we", 128'(bus.mem_we), 128'(e.we));
                    check("acc_re", 128'(bus.mem_re), 128'(!e.we));
                    check("acc_addr", 128'(bus.mem_addr), 128'(e.addr));
                    if (e.we) check("acc_wdata", 128'(bus.mem_wrt_data), 128'(e.data));
                end
            end
            if (bus.done) begin
                check("ready_in_done", 128'(bus.req_ready), 128'(0));
                check("latency", 128'((cyc + 1) - last_acc), 128'(WORDS + 1));
                check("acc_left", 128'(acc_q.size()), 128'(0));
                if (line_q.size() == 0) begin
                    check("line_underflow", 128'(1), 128'(0));
                end else begin
                    l = line_q.pop_front();
                    if (l.wr) begin
                        for (int o = 0; o < WORDS; o++)
                            obs[32*o +: 32] = mem[10'(l.base) | 10'(o)];
                        check("wb_mem", obs, l.line);
                    end else begin
                        check("fill_line", bus.rd_line, l.line);
                    end
                end
            end
        end
    end

    // Drive one request; returns just after its accept edge with valid still
    // high unless drop is set.
    task automatic send(input logic wr, input logic [21:0] addr, input logic [127:0] wdata,
                        input logic drop);
        int            n = 0;
        logic [OFS_W-1:0] st;
        logic [21:0]   base;
        line_t         l;
        acc_t          e;
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
`ifdef WRAP_FILL_EN
        st = addr[OFS_W-1:0];
`else
        st = '0;
`endif
        base = {addr[21:OFS_W], 2'b00};
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) check("accept_timeout", 128'(1), 128'(0));
        l.wr = wr;
        l.base = base;
        for (int i = 0; i < WORDS; i++) begin
            logic [OFS_W-1:0] o;
            o = st + OFS_W'(i);
            e.we   = wr;
            e.addr = base | 22'(o);
            e.data = wdata[32*o +: 32];
            acc_q.push_back(e);
            l.line[32*o +: 32] = wr ? wdata[32*o +: 32] : mem[10'(e.addr)];
        end
        line_q.push_back(l);
        last_acc = cyc + 1;
        @(posedge clk);
        #1;
        if (drop) bus.req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) check("done_timeout", 128'(1), 128'(0));
        @(negedge clk);
    endtask

    initial begin
        int a1;
        logic [127:0] fill_ref;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
        for (int i = 0; i < 4; i++) begin
            mem[10'h104 + i] = 32'hA0 + 32'(i);
            mem[10'h10C + i] = 32'hB0 + 32'(i);
        end
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.mem_rd_data = '0;

        #12;
        check("rst_ready", 128'(bus.req_ready), 128'(1));
        check("rst_done",  128'(bus.done), 128'(0));
        check("rst_re_we", 128'({bus.mem_re, bus.mem_we}), 128'(0));
        check("rst_addr",  128'(bus.mem_addr), 128'(0));
        check("rst_wdata", 128'(bus.mem_wrt_data), 128'(0));
        check("rst_line",  bus.rd_line, 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Plain fill; expected line is fixed, not just taken from the model.
        send(1'b0, 22'h000104, '0, 1'b1);
        wait_done();
        check("fill_104_const", bus.rd_line, {32'hA3, 32'hA2, 32'hA1, 32'hA0});

        // Writeback.
        send(1'b1, 22'h000200, {32'h44, 32'h33, 32'h22, 32'h11}, 1'b1);
        wait_done();
        check("wb_200_w0", 128'(mem[10'h200]), 128'(32'h11));
        check("wb_200_w3", 128'(mem[10'h203]), 128'(32'h44));

        // Mid-line address: order depends on WRAP_FILL_EN, slots never do.
        send(1'b0, 22'h00010E, '0, 1'b1);
        wait_done();
        check("fill_10E_const", bus.rd_line, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
        fill_ref = bus.rd_line;
        send(1'b0, 22'h00010C, '0, 1'b1);
        wait_done();
        check("fill_wrap_same", bus.rd_line, fill_ref);

        // Wrapped writeback.
        send(1'b1, 22'h000243, {32'h0D, 32'h0C, 32'h0B, 32'h0A}, 1'b1);
        wait_done();

        // Back-to-back with req_valid held high.
        @(negedge clk);
        send(1'b1, 22'h000280, {32'h78, 32'h56, 32'h34, 32'h12}, 1'b0);
        a1 = last_acc;
        send(1'b0, 22'h000105, '0, 1'b1);
        check("b2b_spacing", 128'(last_acc - a1), 128'(WORDS + 2));
        wait_done();
        check("b2b_fill", bus.rd_line, {32'hA3, 32'hA2, 32'hA1, 32'hA0});

        // Reset during XFER cycle 2 of a writeback.
        send(1'b1, 22'h000300, {32'h4, 32'h3, 32'h2, 32'h1}, 1'b1);
        @(posedge clk);
        #2;
        check("pre_rst_we", 128'(bus.mem_we), 128'(1));
        rst_n = 1'b0;
        #1;
        check("rst_mid_we", 128'(bus.mem_we), 128'(0));
        check("rst_mid_re", 128'(bus.mem_re), 128'(0));
        check("rst_mid_ready", 128'(bus.req_ready), 128'(1));
        check("rst_mid_line", bus.rd_line, 128'(0));
        check("rst_mid_addr", 128'(bus.mem_addr), 128'(0));
        acc_q.delete();
        line_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(1'b0, 22'h000104, '0, 1'b1);
        wait_done();
        check("post_rst_fill", bus.rd_line, {32'hA3, 32'hA2, 32'hA1, 32'hA0});

        repeat (2) @(negedge clk);
        check("sb_acc_empty", 128'(acc_q.size()), 128'(0));
        check("sb_line_empty", 128'(line_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
